control_sequencer: RTL and testbench

- Hardwired control unit that sits directly upstream of the datapath.
- Reads the instruction register (IR) contents and drives every datapath control strobe cycle by cycle: register in/out enables, PC, IR, Y, Z, MAR, MDR, HI, LO, the memory Read strobe and ALUselect.
- Replaces hand-sequenced strobes with an FSM covering fetch (T0–T2) and execute (T3–T6) for ALU, immediate, multiply/divide, nop and halt instructions.

---
 rtl/control_sequencer.sv | 167 ++++++++++++++++
 tb/tb_control_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: walks fetch (T0-T2) and execute (T3-T6) for the
// current IR and drives every datapath strobe combinationally from state + IR.
module control_sequencer #(
  parameter int OPW = 5,
  parameter int CW  = 19
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Read,
  output logic        Cout,
  output logic [31:0] CSignExt,
  output logic [3:0]  ALUselect,
  output logic        run
);

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_IMM, C_MD, C_UN, C_HALT
  } iclass_t;

  state_t        state_q, state_d;
  iclass_t       iclass;
  logic [3:0]    alu_code;
  logic [OPW-1:0] opcode;
  logic [15:0]   ra_oh, rb_oh, rc_oh;

  assign opcode   = IR[31 -: OPW];
  assign ra_oh    = 16'd1 << IR[26:23];
  assign rb_oh    = 16'd1 << IR[22:19];
  assign rc_oh    = 16'd1 << IR[18:15];
  assign CSignExt = {{(32-CW){IR[CW-1]}}, IR[CW-1:0]};

  // Instruction class and ALU code; unlisted opcodes fall into C_NONE (nop).
  always_comb begin
    iclass   = C_NONE;
    alu_code = 4'b0000;
    case (opcode)
      OPW'(3):  begin iclass = C_R;    alu_code = 4'b0100; end
      OPW'(4):  begin iclass = C_R;    alu_code = 4'b0101; end
      OPW'(5):  begin iclass = C_R;    alu_code = 4'b0110; end
      OPW'(6):  begin iclass = C_R;    alu_code = 4'b0111; end
      OPW'(7):  begin iclass = C_R;    alu_code = 4'b1000; end
      OPW'(8):  begin iclass = C_R;    alu_code = 4'b1001; end
      OPW'(9):  begin iclass = C_R;    alu_code = 4'b1010; end
      OPW'(10): begin iclass = C_R;    alu_code = 4'b1011; end
      OPW'(11): begin iclass = C_IMM;  alu_code = 4'b0100; end
      OPW'(12): begin iclass = C_IMM;  alu_code = 4'b0110; end
      OPW'(13): begin iclass = C_IMM;  alu_code = 4'b0111; end
      OPW'(14): begin iclass = C_MD;   alu_code = 4'b1100; end
      OPW'(15): begin iclass = C_MD;   alu_code = 4'b1101; end
      OPW'(16): begin iclass = C_UN;   alu_code = 4'b1110; end
      OPW'(17): begin iclass = C_UN;   alu_code = 4'b1111; end
      OPW'(27): begin iclass = C_HALT; alu_code = 4'b0000; end
      default:  begin iclass = C_NONE; alu_code = 4'b0000; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    Rin       = 16'h0000;
    Rout      = 16'h0000;
    PCin      = 1'b0;
    PCout     = 1'b0;
    IncPC     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    HIin      = 1'b0;
    HIout     = 1'b0;
    LOin      = 1'b0;
    LOout     = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    Read      = 1'b0;
    Cout      = 1'b0;
    ALUselect = 4'b0000;
    run       = 1'b0;
    case (state_q)
      RST: state_d = T0;
      T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = T1;
      end
      T1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = T2;
      end
      T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        if (iclass == C_HALT)      state_d = HALT;
        else if (iclass == C_NONE) state_d = T0;
        else                       state_d = T3;
      end
      T3: begin
        run = 1'b1;
        state_d = T4;
        if (iclass == C_UN) begin
          Rout = rb_oh; ALUselect = alu_code; Zin = 1'b1;
        end else if (iclass == C_MD) begin
          Rout = ra_oh; Yin = 1'b1;
        end else begin
          Rout = rb_oh; Yin = 1'b1;
        end
      end
      T4: begin
        run = 1'b1;
        state_d = T5;
        if (iclass == C_UN) begin
          Zlowout = 1'b1; Rin = ra_oh;
          state_d = T0;
        end else if (iclass == C_IMM) begin
          Cout = 1'b1; ALUselect = alu_code; Zin = 1'b1;
        end else if (iclass == C_MD) begin
          Rout = rb_oh; ALUselect = alu_code; Zin = 1'b1;
        end else begin
          Rout = rc_oh; ALUselect = alu_code; Zin = 1'b1;
        end
      end
      T5: begin
        run = 1'b1; Zlowout = 1'b1;
        if (iclass == C_MD) begin
          LOin = 1'b1;
          state_d = T6;
        end else begin
          Rin = ra_oh;
          state_d = T0;
        end
      end
      T6: begin
        run = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
        state_d = T0;
      end
      HALT:    state_d = HALT;
      default: state_d = RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed cycle table, hand sequences for halt,
// then random instruction streams checked against a per-instruction cycle queue.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, IncPC, IRin, Yin, Zin, MARin, MDRin, MDRout;
  logic HIin, HIout, LOin, LOout, Zhighout, Zlowout, Read, Cout, run;
  logic [31:0] CSignExt;
  logic [3:0]  ALUselect;

  control_sequencer #(.OPW(5), .CW(19)) dut (
    .clock(clock), .clear(clear), .IR(IR), .Rin(Rin), .Rout(Rout),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Read(Read), .Cout(Cout),
    .CSignExt(CSignExt), .ALUselect(ALUselect), .run(run)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [15:0] PCIN = 16'h8000, PCOUT = 16'h4000, INCPC = 16'h2000,
    IRIN = 16'h1000, YIN = 16'h0800, ZIN = 16'h0400, MARIN = 16'h0200,
    MDRIN = 16'h0100, MDROUT = 16'h0080, HIIN = 16'h0040, HIOUT = 16'h0020,
    LOIN = 16'h0010, LOOUT = 16'h0008, ZHIGHOUT = 16'h0004, ZLOWOUT = 16'h0002,
    READ = 16'h0001;
  localparam logic [15:0] FT0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [15:0] FT1 = ZLOWOUT | PCIN | READ | MDRIN;
  localparam logic [15:0] FT2 = MDROUT | IRIN;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [15:0] strb;
    logic        cout;
    logic [3:0]  alu;
    logic        run;
  } exp_t;

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    exp_t        e;
  } vec_t;

  localparam int EW = $bits(exp_t);

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  vec_t tbl[$];
  logic rst_now, halted, cur_halt;

  function automatic exp_t mk(input logic [15:0] rin, input logic [15:0] rout,
                              input logic [15:0] strb, input logic cout,
                              input logic [3:0] alu, input logic r);
    exp_t e;
    e.rin = rin; e.rout = rout; e.strb = strb; e.cout = cout; e.alu = alu; e.run = r;
    return e;
  endfunction

  function automatic exp_t idle();
    return mk(16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0);
  endfunction

  function automatic exp_t busy(input logic [15:0] rin, input logic [15:0] rout,
                                input logic [15:0] strb, input logic [3:0] alu);
    return mk(rin, rout, strb, 1'b0, alu, 1'b1);
  endfunction

  function automatic vec_t mkv(input logic clr, input logic [31:0] ir, input exp_t e);
    vec_t v;
    v.clr = clr; v.ir = ir; v.e = e;
    return v;
  endfunction

  // Reference: two's-complement value of the 19-bit immediate.
  function automatic logic [31:0] sext_ref(input logic [31:0] ir);
    logic [31:0] v;
    v = {13'h0, ir[18:0]};
    if (ir[18]) v = v - 32'h0008_0000;
    return v;
  endfunction

  function automatic logic [3:0] alu_ref(input logic [4:0] op);
    case (op)
      5'd3, 5'd11: return 4'b0100;
      5'd4:        return 4'b0101;
      5'd5, 5'd12: return 4'b0110;
      5'd6, 5'd13: return 4'b0111;
      5'd7:        return 4'b1000;
      5'd8:        return 4'b1001;
      5'd9:        return 4'b1010;
      5'd10:       return 4'b1011;
      5'd14:       return 4'b1100;
      5'd15:       return 4'b1101;
      5'd16:       return 4'b1110;
      5'd17:       return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

  // Push the full cycle-by-cycle strobe sequence of one instruction.
  task automatic build(input logic [31:0] ir);
    int op;
    logic [15:0] ra, rb, rc;
    logic [3:0] a;
    op = int'(ir[31:27]);
    ra = 16'd1 << ir[26:23];
    rb = 16'd1 << ir[22:19];
    rc = 16'd1 << ir[18:15];
    a  = alu_ref(ir[31:27]);
    cur_halt = (op == 27);
    exp_q.push_back(busy(16'h0, 16'h0, FT0, 4'h0));
    exp_q.push_back(busy(16'h0, 16'h0, FT1, 4'h0));
    exp_q.push_back(busy(16'h0, 16'h0, FT2, 4'h0));
    if (op >= 3 && op <= 10) begin
      exp_q.push_back(busy(16'h0, rb, YIN, 4'h0));
      exp_q.push_back(busy(16'h0, rc, ZIN, a));
      exp_q.push_back(busy(ra, 16'h0, ZLOWOUT, 4'h0));
    end else if (op >= 11 && op <= 13) begin
      exp_q.push_back(busy(16'h0, rb, YIN, 4'h0));
      exp_q.push_back(mk(16'h0, 16'h0, ZIN, 1'b1, a, 1'b1));
      exp_q.push_back(busy(ra, 16'h0, ZLOWOUT, 4'h0));
    end else if (op == 14 || op == 15) begin
      exp_q.push_back(busy(16'h0, ra, YIN, 4'h0));
      exp_q.push_back(busy(16'h0, rb, ZIN, a));
      exp_q.push_back(busy(16'h0, 16'h0, ZLOWOUT | LOIN, 4'h0));
      exp_q.push_back(busy(16'h0, 16'h0, ZHIGHOUT | HIIN, 4'h0));
    end else if (op == 16 || op == 17) begin
      exp_q.push_back(busy(16'h0, rb, ZIN, a));
      exp_q.push_back(busy(ra, 16'h0, ZLOWOUT, 4'h0));
    end
  endtask

  // Drive one cycle's inputs at negedge, then compare outputs 1ns later.
  task automatic step(input logic clr, input logic [31:0] ir, input exp_t e,
                      input string name);
    exp_t act;
    logic [31:0] sx;
    @(negedge clock);
    clear = clr;
    IR    = ir;
    #1;
    act.rin  = Rin;
    act.rout = Rout;
    act.strb = {PCin, PCout, IncPC, IRin, Yin, Zin, MARin, MDRin, MDRout,
                HIin, HIout, LOin, LOout, Zhighout, Zlowout, Read};
    act.cout = Cout;
    act.alu  = ALUselect;
    act.run  = run;
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s strobes: got %h want %h (rin/rout/strb/cout/alu/run)",
               name, act, e);
    end
    sx = sext_ref(ir);
    total++;
    if (CSignExt !== sx) begin
      bad++;
      $display("FAIL %s csignext: got %h want %h", name, CSignExt, sx);
    end
  endtask

  initial begin
    logic [31:0] ir_r;
    logic        clr_r;
    exp_t        e;

    clear = 1'b1;
    IR    = 32'h0;
    repeat (2) @(posedge clock);

    // and R1,R2,R3 ; mul R4,R5 ; addi R2,R2,5 ; unknown ; add with clear in T4 ; neg
    tbl.push_back(mkv(0, 32'h28918000, idle()));
    tbl.push_back(mkv(0, 32'h28918000, busy(16'h0, 16'h0, FT0, 4'h0)));
    tbl.push_back(mkv(0, 32'h28918000, busy(16'h0, 16'h0, FT1, 4'h0)));
    tbl.push_back(mkv(0, 32'h28918000, busy(16'h0, 16'h0, FT2, 4'h0)));
    tbl.push_back(mkv(0, 32'h28918000, busy(16'h0, 16'h0004, YIN, 4'h0)));
    tbl.push_back(mkv(0, 32'h28918000, busy(16'h0, 16'h0008, ZIN, 4'b0110)));
    tbl.push_back(mkv(0, 32'h28918000, busy(16'h0002, 16'h0, ZLOWOUT, 4'h0)));
    tbl.push_back(mkv(0, 32'h72280000, busy(16'h0, 16'h0, FT0, 4'h0)));
    tbl.push_back(mkv(0, 32'h72280000, busy(16'h0, 16'h0, FT1, 4'h0)));
    tbl.push_back(mkv(0, 32'h72280000, busy(16'h0, 16'h0, FT2, 4'h0)));
    tbl.push_back(mkv(0, 32'h72280000, busy(16'h0, 16'h0010, YIN, 4'h0)));
    tbl.push_back(mkv(0, 32'h72280000, busy(16'h0, 16'h0020, ZIN, 4'b1100)));
    tbl.push_back(mkv(0, 32'h72280000, busy(16'h0, 16'h0, ZLOWOUT | LOIN, 4'h0)));
    tbl.push_back(mkv(0, 32'h72280000, busy(16'h0, 16'h0, ZHIGHOUT | HIIN, 4'h0)));
    tbl.push_back(mkv(0, 32'h59100005, busy(16'h0, 16'h0, FT0, 4'h0)));
    tbl.push_back(mkv(0, 32'h59100005, busy(16'h0, 16'h0, FT1, 4'h0)));
    tbl.push_back(mkv(0, 32'h59100005, busy(16'h0, 16'h0, FT2, 4'h0)));
    tbl.push_back(mkv(0, 32'h59100005, busy(16'h0, 16'h0004, YIN, 4'h0)));
    tbl.push_back(mkv(0, 32'h59100005, mk(16'h0, 16'h0, ZIN, 1'b1, 4'b0100, 1'b1)));
    tbl.push_back(mkv(0, 32'h5917FFFF, busy(16'h0004, 16'h0, ZLOWOUT, 4'h0)));
    tbl.push_back(mkv(0, 32'hF8000000, busy(16'h0, 16'h0, FT0, 4'h0)));
    tbl.push_back(mkv(0, 32'hF8000000, busy(16'h0, 16'h0, FT1, 4'h0)));
    tbl.push_back(mkv(0, 32'hF8000000, busy(16'h0, 16'h0, FT2, 4'h0)));
    tbl.push_back(mkv(0, 32'h18918000, busy(16'h0, 16'h0, FT0, 4'h0)));
    tbl.push_back(mkv(0, 32'h18918000, busy(16'h0, 16'h0, FT1, 4'h0)));
    tbl.push_back(mkv(0, 32'h18918000, busy(16'h0, 16'h0, FT2, 4'h0)));
    tbl.push_back(mkv(0, 32'h18918000, busy(16'h0, 16'h0004, YIN, 4'h0)));
    tbl.push_back(mkv(1, 32'h18918000, busy(16'h0, 16'h0008, ZIN, 4'b0100)));
    tbl.push_back(mkv(0, 32'h18918000, idle()));
    tbl.push_back(mkv(0, 32'h80880000, busy(16'h0, 16'h0, FT0, 4'h0)));
    tbl.push_back(mkv(0, 32'h80880000, busy(16'h0, 16'h0, FT1, 4'h0)));
    tbl.push_back(mkv(0, 32'h80880000, busy(16'h0, 16'h0, FT2, 4'h0)));
    tbl.push_back(mkv(0, 32'h80880000, busy(16'h0, 16'h0002, ZIN, 4'b1110)));
    tbl.push_back(mkv(0, 32'h80880000, busy(16'h0002, 16'h0, ZLOWOUT, 4'h0)));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].clr, tbl[i].ir, tbl[i].e, $sformatf("vec%0d", i));

    // halt: fetch, then HALT holds until clear, then RST and T0
    step(0, 32'hD8000000, busy(16'h0, 16'h0, FT0, 4'h0), "halt_t0");
    step(0, 32'hD8000000, busy(16'h0, 16'h0, FT1, 4'h0), "halt_t1");
    step(0, 32'hD8000000, busy(16'h0, 16'h0, FT2, 4'h0), "halt_t2");
    for (int i = 0; i < 12; i++)
      step(0, 32'hD8000000, idle(), $sformatf("halt_hold%0d", i));
    step(1, 32'hD8000000, idle(), "halt_clear");
    step(0, 32'hD8000000, idle(), "halt_rst");
    step(1, 32'hD8000000, busy(16'h0, 16'h0, FT0, 4'h0), "halt_restart_t0");

    // random instruction stream against the queue model (starts in RST)
    rst_now  = 1'b1;
    halted   = 1'b0;
    cur_halt = 1'b0;
    exp_q.delete();
    ir_r = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      clr_r = ($urandom_range(0, 39) == 0);
      if (exp_q.size() == 0) ir_r = {5'($urandom_range(0, 31)), 27'($urandom)};
      if (rst_now || halted) begin
        e = idle();
      end else begin
        if (exp_q.size() == 0) build(ir_r);
        e = exp_t'(exp_q.pop_front());
      end
      step(clr_r, ir_r, e, "rand");
      if (clr_r) begin
        rst_now = 1'b1;
        halted  = 1'b0;
        exp_q.delete();
      end else begin
        if (!rst_now && !halted && exp_q.size() == 0 && cur_halt) halted = 1'b1;
        rst_now = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
